// File: rtl/dsp_cfg_bl_wl_programmer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dsp_cfg_bl_wl_programmer : streams an 85-bit mode word in over a byte
// handshake and writes it bit-serially into the tile's RS-latch bank.
// Revision 1.0
// ============================================================================
module dsp_cfg_bl_wl_programmer #(
    parameter int NUM_BITS = 85,
    parameter int DATA_W   = 8,
    parameter int WL_PULSE = 2
) (
    input  logic                prog_clk,
    input  logic                global_resetn,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic [DATA_W-1:0]   cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [NUM_BITS-1:0] bl,
    output logic [NUM_BITS-1:0] wl,
    output logic                busy,
    output logic                done
);

    localparam int NUM_BYTES = (NUM_BITS + DATA_W - 1) / DATA_W;
    localparam int SR_W      = NUM_BYTES * DATA_W;
    localparam int IDX_W     = $clog2(NUM_BITS);
    localparam int BYTE_W    = $clog2(NUM_BYTES + 1);
    localparam int PCNT_W    = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BITS - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
    localparam logic [PCNT_W-1:0] LAST_PCNT = PCNT_W'(WL_PULSE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]          state_q,    state_d;
    logic [SR_W-1:0]     sr_q,       sr_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [PCNT_W-1:0]   pcnt_q,     pcnt_d;
    logic [NUM_BITS-1:0] bl_q,       bl_d;
    logic [NUM_BITS-1:0] wl_q,       wl_d;
    logic                done_q,     done_d;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        byte_cnt_d = byte_cnt_q;
        idx_d      = idx_q;
        pcnt_d     = pcnt_q;
        done_d     = 1'b0;

        if (cfg_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        state_d    = S_LOAD;
                        byte_cnt_d = '0;
                        sr_d       = '0;
                    end
                end
                S_LOAD: begin
                    // Bytes enter at the top so byte 0 ends up at bit 0;
                    // overflow bits of the final byte land above NUM_BITS.
                    if (cfg_valid) begin
                        sr_d       = {cfg_data, sr_q[SR_W-1:DATA_W]};
                        byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_d = S_SETUP;
                            idx_d   = '0;
                        end
                    end
                end
                S_SETUP: begin
                    state_d = S_PULSE;
                    pcnt_d  = '0;
                end
                S_PULSE: begin
                    if (pcnt_q == LAST_PCNT) begin
                        state_d = S_HOLD;
                    end else begin
                        pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_SETUP;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // bl only moves on SETUP entry, where wl is already low.
        bl_d = bl_q;
        if (state_d == S_IDLE) begin
            bl_d = '0;
        end else if (state_d == S_SETUP) begin
            bl_d = {{(NUM_BITS-1){1'b0}}, sr_d[idx_d]} << idx_d;
        end

        wl_d = '0;
        if (state_d == S_PULSE) begin
            wl_d = {{(NUM_BITS-1){1'b0}}, 1'b1} << idx_d;
        end
    end

    always_ff @(posedge prog_clk or negedge global_resetn) begin
        if (!global_resetn) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            byte_cnt_q <= '0;
            idx_q      <= '0;
            pcnt_q     <= '0;
            bl_q       <= '0;
            wl_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            byte_cnt_q <= byte_cnt_d;
            idx_q      <= idx_d;
            pcnt_q     <= pcnt_d;
            bl_q       <= bl_d;
            wl_q       <= wl_d;
            done_q     <= done_d;
        end
    end

    assign cfg_ready = (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);
    assign bl        = bl_q;
    assign wl        = wl_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_cfg_bl_wl_programmer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dsp_cfg_bl_wl_programmer : scoreboard bench with an RS-latch bank model.
// Revision 1.0
// ============================================================================
module tb_dsp_cfg_bl_wl_programmer;

    localparam int NB       = 85;
    localparam int DW       = 8;
    localparam int NBYTES   = 11;
    localparam int WLP      = 2;
    localparam int PROG_CYC = NB * (WLP + 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          ready;
    logic [NB-1:0] bl;
    logic [NB-1:0] wl;
    logic          busy;
    logic          done;

    dsp_cfg_bl_wl_programmer #(
        .NUM_BITS (NB),
        .DATA_W   (DW),
        .WL_PULSE (WLP)
    ) u_dut (
        .prog_clk      (clk),
        .global_resetn (rst_n),
        .cfg_start     (start),
        .cfg_abort     (abort),
        .cfg_data      (data),
        .cfg_valid     (valid),
        .cfg_ready     (ready),
        .bl            (bl),
        .wl            (wl),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] idx;
        logic       val;
    } sb_t;

    sb_t           sb_q[$];
    logic [DW-1:0] stim [NBYTES];
    logic [NB-1:0] latch    = '0;
    logic [NB-1:0] exp_img  = '0;
    logic [NB-1:0] prev_bl  = '0;
    logic [NB-1:0] prev_wl  = '0;
    logic          prev_done = 1'b0;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            xfer_cyc = 0;
    int            done_cnt = 0;
    int            width    = 0;
    int            exp_width = WLP;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Latch bank model plus per-cycle protocol checks on bl/wl/done.
    always @(negedge clk) begin
        sb_t           e;
        logic [NB-1:0] one;
        if (wl != '0) begin
            check("wl_onehot", 128'($countones(wl)), 128'd1);
            check("bl_stable", bl, prev_bl);
            for (int i = 0; i < NB; i++) if (wl[i]) latch[i] = bl[i];
            if (prev_wl == '0) begin
                check("sb_underflow", 128'(sb_q.size() == 0), 128'd0);
                if (sb_q.size() != 0) begin
                    e   = sb_q.pop_front();
                    one = '0;
                    one[e.idx] = 1'b1;
                    check("wl_pos", wl, one);
                    check("bl_val", bl, e.val ? one : '0);
                end
            end
            width++;
        end else begin
            if (prev_wl != '0) check("wl_width", 128'(width), 128'(exp_width));
            width = 0;
        end
        if (done) begin
            check("done_latency", 128'(cyc - xfer_cyc), 128'(PROG_CYC));
            check("done_sb_drain", 128'(sb_q.size()), 128'd0);
            check("done_single", 128'(prev_done), 128'd0);
            done_cnt++;
        end
        prev_bl   = bl;
        prev_wl   = wl;
        prev_done = done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input bit rnd, output int ready_cycles);
        int k;
        int guard;
        int pos;
        k = 0;
        guard = 0;
        ready_cycles = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        while (k < NBYTES && guard < 2000) begin
            valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            data  = valid ? stim[k] : DW'($urandom);
            if (ready) ready_cycles++;
            if (valid && ready) begin
                for (int j = 0; j < DW; j++) begin
                    pos = k * DW + j;
                    if (pos < NB) begin
                        sb_q.push_back({7'(pos), stim[k][j]});
                        exp_img[pos] = stim[k][j];
                    end
                end
                if (k == NBYTES - 1) xfer_cyc = cyc + 1;
                k++;
            end
            guard++;
            tick();
        end
        valid = 1'b0;
        check("load_bound", 128'(k), 128'(NBYTES));
    endtask

    task automatic wait_done();
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < PROG_CYC + 50) begin
            if (n == 40) begin
                start = 1'b1;
                valid = 1'b1;
                data  = 8'h3C;
            end else begin
                start = 1'b0;
                valid = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        valid = 1'b0;
        check("done_seen", 128'(done_cnt - d0), 128'd1);
        tick();
        check("idle_after_done", {busy, ready, done}, 3'b000);
    endtask

    task automatic wait_wl(input int idx);
        int n;
        n = 0;
        while (wl[idx] !== 1'b1 && n < PROG_CYC + 50) begin
            tick();
            n++;
        end
        check("wl_reached", 128'(wl[idx]), 128'd1);
    endtask

    initial begin
        int            rc;
        int            d0;
        logic [NB-1:0] old_img;
        logic [NB-1:0] mask;

        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_outputs", {bl, wl, ready, busy, done}, '0);
        rst_n = 1'b1;
        tick();
        check("idle_outputs", {ready, busy, done}, 3'b000);

        // All ones, back-to-back; stray start/valid injected mid-program.
        for (int i = 0; i < NBYTES; i++) stim[i] = 8'hFF;
        send(1'b0, rc);
        check("ready_cycles", 128'(rc), 128'(NBYTES));
        check("ready_dropped", 128'(ready), 128'd0);
        wait_done();
        check("img_ones", latch, {NB{1'b1}});

        // Sparse pattern: only bits 0,2,5,7 set.
        stim[0] = 8'hA5;
        for (int i = 1; i < NBYTES; i++) stim[i] = 8'h00;
        send(1'b0, rc);
        wait_done();
        check("img_a5", latch, NB'(8'hA5));

        // Random valid throttling, random data, top byte overflow discarded.
        for (int i = 0; i < NBYTES - 1; i++) stim[i] = DW'($urandom);
        stim[NBYTES-1] = 8'hE0;
        send(1'b1, rc);
        wait_done();
        check("img_random", latch, exp_img);
        check("img_top5", 128'(latch[84:80]), 128'd0);

        // Abort in the second PULSE cycle of bit 10.
        old_img = latch;
        for (int i = 0; i < NBYTES; i++) stim[i] = 8'hFF;
        d0 = done_cnt;
        send(1'b0, rc);
        wait_wl(10);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", {bl, wl, busy, ready}, '0);
        sb_q.delete();
        repeat (5) tick();
        check("abort_no_done", 128'(done_cnt - d0), 128'd0);
        mask = ~(NB'(1) << 10);
        check("abort_img", latch & mask, ((old_img | NB'(10'h3FF)) & mask));
        exp_img = latch;

        // Abort beats start while idle.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle", {busy, ready}, 2'b00);

        // Asynchronous reset during PULSE of bit 40, then full reload.
        for (int i = 0; i < NBYTES; i++) stim[i] = DW'($urandom);
        send(1'b0, rc);
        wait_wl(40);
        exp_width = 1;
        #1 rst_n = 1'b0;
        #1 check("async_rst", {bl, wl, busy, done}, '0);
        tick();
        rst_n = 1'b1;
        exp_width = WLP;
        sb_q.delete();
        tick();
        check("post_rst_idle", {busy, ready, done}, 3'b000);
        for (int i = 0; i < NBYTES; i++) stim[i] = DW'($urandom);
        send(1'b1, rc);
        wait_done();
        check("img_reload", latch, exp_img);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
